spi_byte_master: RTL and testbench

Byte-level SPI master (mode 0, MSB first) for the flash port of the iCE40 bootloader top. It sits directly downstream of the bootloader command engine, which feeds it one byte per valid/ready handshake and controls chip select through `select`. For every byte shifted out on `spi_so`, the block returns the byte simultaneously sampled on `spi_si` through a valid/ready output channel. It replaces ad-hoc bit-banging and guarantees a fixed SCK rate and frame timing.

---
 rtl/spi_byte_master_pkg.sv | 20 ++
 rtl/spi_byte_master_if.sv | 25 ++
 rtl/spi_byte_master_clk_div.sv | 33 +++
 rtl/spi_byte_master.sv | 161 ++++++++++++++++
 tb/tb_spi_byte_master.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_byte_master_pkg.sv
// Shared definitions for the byte-level SPI master: FSM encoding,
// frame width and the divider-width helper.
package spi_byte_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

  localparam int SPI_BITS = 8;

  // Width of a counter that must hold CLK_DIV-1, never narrower than one bit.
  function automatic int div_width(input int clk_div);
    int w;
    w = $clog2(clk_div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte handshake between the bootloader command engine (master side)
// and the SPI byte master (slave side).
interface spi_byte_master_if;
  import spi_byte_master_pkg::*;

  logic                select;
  logic                tx_valid;
  logic [SPI_BITS-1:0] tx_data;
  logic                tx_ready;
  logic                rx_valid;
  logic [SPI_BITS-1:0] rx_data;
  logic                rx_ready;
  logic                busy;

  modport master (
    output select, tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  select, tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data, busy
  );

endinterface

// File: rtl/spi_byte_master_clk_div.sv
// Reloadable down-counter that times each SCK half-period.
// o_zero flags the last clk of the current half-period.
module spi_byte_master_clk_div
  import spi_byte_master_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int               DIV_W  = div_width(CLK_DIV);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  // Reload wins over decrement; the counter parks at zero until reloaded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0, MSB-first SPI byte master. Each accepted tx byte is shifted out
// while the byte on MISO is captured and returned on the rx channel.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no transfer; SS follows select; accepts a byte when ready
// LOW     | SCK low half-period, MOSI stable; MISO sampled at its end
// HIGH    | SCK high half-period; next MOSI bit (or rx) at its end
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  spi_byte_master_if.slave   if_bus,
  output logic               o_spi_sck,
  output logic               o_spi_so,
  input  logic               i_spi_si,
  output logic               o_spi_ss
);

  localparam int BIT_W = $clog2(SPI_BITS);

  spi_state_e          r_state;
  spi_state_e          w_state_nxt;
  logic [SPI_BITS-1:0] r_shift;
  logic [BIT_W-1:0]    r_bit;
  logic                r_sck;
  logic                r_so;
  logic                r_ss;
  logic                r_rx_valid;
  logic [SPI_BITS-1:0] r_rx_data;

  logic w_tx_ready;
  logic w_accept;
  logic w_div_load;
  logic w_div_en;
  logic w_div_zero;
  logic w_rise;
  logic w_fall;
  logic w_last;

  spi_byte_master_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_div_load),
    .i_en    (w_div_en),
    .o_zero  (w_div_zero)
  );

  // Holding rx_valid off tx_ready makes rx overrun impossible.
  assign w_tx_ready = (r_state == ST_IDLE) && !r_ss && !r_rx_valid;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the per-cycle strobes that steer the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_div_load  = 1'b0;
    w_div_en    = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tx_ready && if_bus.tx_valid) begin
          w_accept    = 1'b1;
          w_div_load  = 1'b1;
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_div_zero) begin
          w_rise      = 1'b1;
          w_div_load  = 1'b1;
          w_state_nxt = ST_HIGH;
        end else begin
          w_div_en = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_div_zero) begin
          w_fall = 1'b1;
          if (r_bit == BIT_W'(SPI_BITS - 1)) begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_div_load  = 1'b1;
            w_state_nxt = ST_LOW;
          end
        end else begin
          w_div_en = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift datapath, SPI pins and rx holding register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_bit      <= '0;
      r_sck      <= 1'b0;
      r_so       <= 1'b0;
      r_ss       <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      if (w_accept) begin
        r_shift <= if_bus.tx_data;
        r_so    <= if_bus.tx_data[SPI_BITS-1];
        r_bit   <= '0;
      end
      // MISO enters at the LSB as the sent bit leaves at the MSB.
      if (w_rise) begin
        r_sck   <= 1'b1;
        r_shift <= {r_shift[SPI_BITS-2:0], i_spi_si};
      end
      if (w_fall) begin
        r_sck <= 1'b0;
        if (!w_last) begin
          r_bit <= r_bit + 1'b1;
          r_so  <= r_shift[SPI_BITS-1];
        end
      end
      if (w_last) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && if_bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      // SS may only move between bytes; a deselect mid-byte waits for IDLE.
      if (r_state == ST_IDLE) begin
        r_ss <= w_accept ? 1'b0 : !if_bus.select;
      end else begin
        r_ss <= 1'b0;
      end
    end
  end

  assign if_bus.tx_ready = w_tx_ready;
  assign if_bus.rx_valid = r_rx_valid;
  assign if_bus.rx_data  = r_rx_data;
  assign if_bus.busy     = (r_state != ST_IDLE);
  assign o_spi_sck       = r_sck;
  assign o_spi_so        = r_so;
  assign o_spi_ss        = r_ss;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: a loopback instance (CLK_DIV=1) and an
// instance with a slave model (CLK_DIV=3), each with an rx scoreboard.
module tb_spi_byte_master;

  logic clk;
  logic rst1, rst3;
  logic o_sck1, o_so1, o_ss1;
  logic o_sck3, o_so3, o_ss3, si3;
  logic [7:0] slv_byte;
  int   slv_cnt;

  int n_checks;
  int n_fail;

  logic [7:0] q1[$];
  logic [7:0] q3[$];

  spi_byte_master_if if1();
  spi_byte_master_if if3();

  spi_byte_master #(.CLK_DIV(1)) dut1 (
    .i_clk     (clk),
    .i_reset   (rst1),
    .if_bus    (if1),
    .o_spi_sck (o_sck1),
    .o_spi_so  (o_so1),
    .i_spi_si  (o_so1),
    .o_spi_ss  (o_ss1)
  );

  spi_byte_master #(.CLK_DIV(3)) dut3 (
    .i_clk     (clk),
    .i_reset   (rst3),
    .if_bus    (if3),
    .o_spi_sck (o_sck3),
    .o_spi_so  (o_so3),
    .i_spi_si  (si3),
    .o_spi_ss  (o_ss3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: present bit 7 first, advance after every falling SCK.
  initial slv_cnt = 0;
  always @(negedge o_sck3 or posedge o_ss3) begin
    if (o_ss3) slv_cnt <= 0;
    else       slv_cnt <= slv_cnt + 1;
  end
  assign si3 = (slv_cnt < 8) ? slv_byte[3'(7 - slv_cnt)] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: compare each rx byte as it is handed over.
  always @(negedge clk) begin
    if (!rst1 && if1.rx_valid && if1.rx_ready) begin
      if (q1.size() == 0) chk("rx1_unexpected", {24'd0, if1.rx_data}, 32'hFFFF_FFFF);
      else                chk("rx1_data", {24'd0, if1.rx_data}, {24'd0, q1.pop_front()});
    end
    if (!rst3 && if3.rx_valid && if3.rx_ready) begin
      if (q3.size() == 0) chk("rx3_unexpected", {24'd0, if3.rx_data}, 32'hFFFF_FFFF);
      else                chk("rx3_data", {24'd0, if3.rx_data}, {24'd0, q3.pop_front()});
    end
  end

  // One byte on dut1. Index k counts clk edges after the accept edge.
  task automatic xfer1(input logic [7:0] d, input int drop_k, input int rst_k,
                       output logic [15:0] sck_pat, output logic [7:0] mosi,
                       output int rv_k, output logic [7:0] rxd,
                       output logic ss16, output logic ss17, output logic rdy17);
    int n;
    sck_pat = '0; mosi = '0; rv_k = -1; rxd = '0;
    ss16 = 1'b0; ss17 = 1'b0; rdy17 = 1'b0;
    @(negedge clk);
    if1.tx_valid = 1'b1;
    if1.tx_data  = d;
    n = 0;
    while (!if1.tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("tx1_accept_timeout", n, 0);
      if1.tx_valid = 1'b0;
      return;
    end
    if (rst_k < 0) q1.push_back(d);
    @(posedge clk);
    #1 if1.tx_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k < 16) sck_pat[k] = o_sck1;
      if (k < 16 && (k % 2) == 1) mosi[3'(7 - (k - 1) / 2)] = o_so1;
      if (if1.rx_valid && rv_k < 0) begin
        rv_k = k;
        rxd  = if1.rx_data;
      end
      if (k == 16) ss16 = o_ss1;
      if (k == 17) begin
        ss17  = o_ss1;
        rdy17 = if1.tx_ready;
      end
      if (k == drop_k) if1.select = 1'b0;
      if (k == rst_k) begin
        rst1 = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [15:0] sck_pat;
    logic [7:0]  mosi, rxd;
    logic        ss16, ss17, rdy17;
    int          rv_k, bad, n;
    int          rises, first_r, second_r, rv3;
    logic        prev;
    logic [7:0]  mosi3, rxd3;

    n_checks = 0;
    n_fail   = 0;
    rst1 = 1'b1; rst3 = 1'b1;
    if1.select = 1'b1; if1.tx_valid = 1'b1; if1.tx_data = 8'hA5; if1.rx_ready = 1'b1;
    if3.select = 1'b1; if3.tx_valid = 1'b0; if3.tx_data = 8'h00; if3.rx_ready = 1'b1;
    slv_byte = 8'h3C;

    // Reset held three cycles with select and tx_valid high.
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (o_ss1 !== 1'b1 || o_sck1 !== 1'b0 || if1.tx_ready !== 1'b0 ||
          if1.rx_valid !== 1'b0 || if1.busy !== 1'b0 || o_so1 !== 1'b0)
        bad++;
    end
    chk("reset_outputs", bad, 0);
    chk("reset_rx_data", {24'd0, if1.rx_data}, 32'h0);
    rst1 = 1'b0; rst3 = 1'b0;
    if1.tx_valid = 1'b0;
    @(negedge clk);
    chk("reset_ss_after_release", {31'd0, o_ss1}, 32'd0);

    // Loopback 0xA5.
    xfer1(8'hA5, -1, -1, sck_pat, mosi, rv_k, rxd, ss16, ss17, rdy17);
    chk("lb_sck_pattern", {16'd0, sck_pat}, 32'hAAAA);
    chk("lb_mosi", {24'd0, mosi}, 32'hA5);
    chk("lb_rx_valid_cycle", rv_k, 16);
    chk("lb_rx_data", {24'd0, rxd}, 32'hA5);
    chk("lb_b2b_tx_ready", {31'd0, rdy17}, 32'd1);
    chk("lb_so_holds_last", {31'd0, o_so1}, 32'd1);

    // Backpressure: first byte not consumed for 40 cycles.
    if1.rx_ready = 1'b0;
    xfer1(8'h01, -1, -1, sck_pat, mosi, rv_k, rxd, ss16, ss17, rdy17);
    chk("bp_first_rv_cycle", rv_k, 16);
    if1.tx_valid = 1'b1;
    if1.tx_data  = 8'h02;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (if1.rx_valid !== 1'b1 || if1.tx_ready !== 1'b0 || if1.busy !== 1'b0) bad++;
    end
    chk("bp_held_no_accept", bad, 0);
    chk("bp_rx_data_stable", {24'd0, if1.rx_data}, 32'h01);
    @(posedge clk);
    #1 if1.rx_ready = 1'b1;
    if1.tx_valid = 1'b0;
    xfer1(8'h02, -1, -1, sck_pat, mosi, rv_k, rxd, ss16, ss17, rdy17);
    chk("bp_second_rv_cycle", rv_k, 16);
    chk("bp_second_mosi", {24'd0, mosi}, 32'h02);

    // Deselect after bit 3 of 0xFF.
    xfer1(8'hFF, 8, -1, sck_pat, mosi, rv_k, rxd, ss16, ss17, rdy17);
    chk("desel_rv_cycle", rv_k, 16);
    chk("desel_ss_at_idle", {31'd0, ss16}, 32'd0);
    chk("desel_ss_after_idle", {31'd0, ss17}, 32'd1);
    if1.tx_valid = 1'b1;
    if1.tx_data  = 8'h55;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (if1.tx_ready !== 1'b0 || if1.busy !== 1'b0 || o_ss1 !== 1'b1) bad++;
    end
    chk("desel_no_accept", bad, 0);
    if1.tx_valid = 1'b0;
    if1.select   = 1'b1;

    // Reset during bit 5 (SCK high).
    xfer1(8'h5A, -1, 11, sck_pat, mosi, rv_k, rxd, ss16, ss17, rdy17);
    chk("rst_mid_sck_before", {31'd0, o_sck1}, 32'd1);
    @(negedge clk);
    chk("rst_mid_sck", {31'd0, o_sck1}, 32'd0);
    chk("rst_mid_ss", {31'd0, o_ss1}, 32'd1);
    chk("rst_mid_busy", {31'd0, if1.busy}, 32'd0);
    rst1 = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (if1.rx_valid !== 1'b0) bad++;
    end
    chk("rst_mid_no_rx_valid", bad, 0);
    xfer1(8'h3C, -1, -1, sck_pat, mosi, rv_k, rxd, ss16, ss17, rdy17);
    chk("rst_after_rv_cycle", rv_k, 16);
    chk("rst_after_rx_data", {24'd0, rxd}, 32'h3C);

    // CLK_DIV=3 with slave returning 0x3C while 0x9F goes out.
    @(negedge clk);
    if3.tx_valid = 1'b1;
    if3.tx_data  = 8'h9F;
    n = 0;
    while (!if3.tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx3_accept_wait", (n >= 100) ? 1 : 0, 0);
    q3.push_back(8'h3C);
    @(posedge clk);
    #1 if3.tx_valid = 1'b0;
    rises = 0; first_r = -1; second_r = -1; rv3 = -1; prev = 1'b0;
    mosi3 = '0; rxd3 = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_sck3 && !prev) begin
        if (first_r < 0) first_r = k;
        else if (second_r < 0) second_r = k;
        if (rises < 8) mosi3[3'(7 - rises)] = o_so3;
        rises++;
      end
      prev = o_sck3;
      if (if3.rx_valid && rv3 < 0) begin
        rv3  = k;
        rxd3 = if3.rx_data;
      end
    end
    chk("div3_first_rise", first_r, 3);
    chk("div3_sck_period", second_r - first_r, 6);
    chk("div3_rise_count", rises, 8);
    chk("div3_mosi", {24'd0, mosi3}, 32'h9F);
    chk("div3_rv_cycle", rv3, 48);
    chk("div3_rx_data", {24'd0, rxd3}, 32'h3C);

    repeat (4) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
